// File: rtl/irq_pending_latch_pkg.sv
// Shared types for the interrupt front-end and the 8-to-3 encoder wrapper.
package irq_pkg;
    localparam int IRQ_N    = 8;
    localparam int IRQ_ID_W = $clog2(IRQ_N);

    typedef logic [IRQ_N-1:0]    irq_vec_t;
    typedef logic [IRQ_ID_W-1:0] irq_id_t;
endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/ack/mask bundle between the interrupt sources, the consumer and irq_pending_latch.
interface irq_pending_latch_if;
    import irq_pkg::*;

    irq_vec_t req_in;
    logic     mask_wr;
    irq_vec_t mask_data;
    logic     ack;
    irq_id_t  ack_id;
    logic     ovf_clr;
    irq_vec_t pend_out;
    logic     irq;
    irq_vec_t ovf;

    modport master (
        output req_in, mask_wr, mask_data, ack, ack_id, ovf_clr,
        input  pend_out, irq, ovf
    );

    modport slave (
        input  req_in, mask_wr, mask_data, ack, ack_id, ovf_clr,
        output pend_out, irq, ovf
    );
endinterface

// File: rtl/irq_pending_latch_edge_detect.sv
// Rising-edge detector for the request vector; `IRQ_SYNC_EN adds a two-flop
// synchronizer per line ahead of the edge register.
module irq_edge_detect
    import irq_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  irq_vec_t req_in,
    output irq_vec_t rise
);
    irq_vec_t req_s;
    irq_vec_t req_d, req_q;

`ifdef IRQ_SYNC_EN
    irq_vec_t sync1_d, sync1_q;
    irq_vec_t sync2_d, sync2_q;

    always_comb begin
        sync1_d = req_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    always_comb begin
        req_d = req_s;
    end

    // req_q clears in reset so a line held high across release counts as one event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign rise = req_s & ~req_q;
endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending/overflow latch with enable mask and indexed acknowledge,
// feeding the priority encoder. Optional `IRQ_SYNC_EN synchronizes req_in.
module irq_pending_latch
    import irq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    irq_pending_latch_if.slave  bus
);
    localparam int N    = IRQ_N;
    localparam int ID_W = IRQ_ID_W;

    irq_vec_t rise;
    irq_vec_t clr;
    irq_vec_t pending_d, pending_q;
    irq_vec_t ovf_d, ovf_q;
    irq_vec_t mask_en_d, mask_en_q;

    irq_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (bus.req_in),
        .rise   (rise)
    );

    // A rise on the bit being acked is a fresh event, not an overflow.
    always_comb begin
        clr = '0;
        if (bus.ack) begin
            clr = irq_vec_t'(1) << bus.ack_id;
        end
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = (bus.ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr);
        mask_en_d = bus.mask_wr ? bus.mask_data : mask_en_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= '0;
            mask_en_q <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            mask_en_q <= mask_en_d;
        end
    end

    assign bus.pend_out = pending_q & mask_en_q;
    assign bus.irq      = |bus.pend_out;
    assign bus.ovf      = ovf_q;

    if (N != (1 << ID_W)) begin : g_bad_width
        $error("irq_pending_latch: N must be a power of 2");
    end
endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Front-end stage for the 8-to-3 priority encoder. Captures rising edges on 8 asynchronous-source request lines into sticky pending bits, applies a per-line enable mask, and drives the masked pending vector into the encoder's `din`. The consumer returns the serviced line index on an acknowledge strobe, which clears that pending bit. A per-line sticky overflow flag records lost events.

## Interface
- `N`, 8: number of request lines; must equal the encoder input width and be a power of 2.
- `ID_W`, `$clog2(N)` = 3: width of the acknowledge index; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on `clk` rising edge.
- `req_in`  in  N  raw request lines; a 0->1 transition is one event.
- `mask_wr`  in  1  load `mask_data` into the enable mask.
- `mask_data`  in  N  new enable mask (1 = line enabled).
- `ack`  in  1  one-cycle acknowledge strobe from the consumer.
- `ack_id`  in  ID_W  index of the line being acknowledged; valid when `ack`=1.
- `ovf_clr`  in  1  clear all overflow flags.
- `pend_out`  out  N  pending & enable; connects to encoder `din`.
- `irq`  out  1  OR-reduction of `pend_out`.
- `ovf`  out  N  sticky per-line overflow flags.

## Operation
- Edge detect: `req_q` register holds the previous sampled `req_in`. `rise = req_s & ~req_q`, where `req_s` is `req_in`, or the synchronizer output when `IRQ_SYNC_EN` is defined.
- Ack decode: `clr = ack ? (1 << ack_id) : 0`.
- Pending update: `pending <= (pending & ~clr) | rise`.
- Overflow update: `ovf <= (ovf_clr ? 0 : ovf) | (rise & pending & ~clr)`.
- Mask update: `mask_en <= mask_wr ? mask_data : mask_en`.
- Outputs: `pend_out = pending & mask_en` and `irq = |pend_out`. Both are combinational from registers, with no extra register stage.
- Masked lines still latch pending and overflow. Enabling the mask later exposes the stored event.
- Boundary cases:
  - Rise and ack on the same bit in the same cycle: pending stays 1 (a new event) and `ovf` is not set.
  - Rise on an already-pending bit with no ack on that bit: `ovf` bit sets.
  - `ovf_clr` and a new overflow in the same cycle: set wins.
  - Ack of a non-pending bit: no effect.
  - Ack of a masked bit: clears it.
  - `mask_wr` together with ack or rise: all updates apply independently in the same edge.
- Reset (`rst_n`=0 at an edge):
  - `pending`, `ovf`, `mask_en` and `req_q` clear to 0, as do the synchronizer flops when present.
  - `pend_out`=0, `irq`=0, `ovf`=0 from the next cycle.
  - A line held high across reset release produces one event (since `req_q`=0).
  - Reset mid-operation discards all pending events, with no partial state retained.

## Timing
- Without `IRQ_SYNC_EN`: `req_in` high set-up before edge k gives `pend_out`/`irq` high after edge k, a latency of 1 cycle.
- With `IRQ_SYNC_EN`: latency is 3 cycles (2 synchronizer flops + pending).
- Ack: `ack` at edge k clears the bit after edge k. Encoder output reflects the change in the same cycle, combinationally downstream.
- Mask write at edge k takes effect on `pend_out` after edge k.
- Requests must stay low for at least 1 sample (3 with sync) between events; narrower pulses may be missed. This is a source requirement, not checked.

## Configuration
- `IRQ_SYNC_EN` defined: a two-flop synchronizer on each `req_in` bit precedes edge detection. Use this for asynchronous sources.
- `IRQ_SYNC_EN` undefined: `req_in` is assumed synchronous to `clk` and feeds `req_q`/rise directly. Latency is 1 cycle.
- Port list is identical in both builds.

## Structure
- Shared package `irq_pkg`: `IRQ_N`=8, `IRQ_ID_W`=3, and typedefs `irq_vec_t` (logic [IRQ_N-1:0]) and `irq_id_t` (logic [IRQ_ID_W-1:0]). The encoder wrapper uses the same types.
- Sub-module `irq_edge_detect`: one instance per N-wide vector. It contains the optional synchronizer, `req_q` and the rise output.
- The top level holds the pending/ovf/mask registers and ack decode.

## Test plan
- Reset then `mask_data`=8'hFF; pulse `req_in`=8'b00000100 → `pend_out`=8'h04 and `irq`=1 after 1 cycle (3 with sync). Then `ack`, `ack_id`=2 → `pend_out`=8'h00, `irq`=0 next cycle.
- Mask 8'h0F; raise `req_in`[6] → `pend_out`=0 and `irq`=0. Write mask 8'hFF → `pend_out`=8'h40 next cycle.
- `req_in`[0] pulsed twice with no ack → `pend_out`[0]=1 and `ovf`=8'h01. Then `ovf_clr` → `ovf`=0 and pending stays set.
- Same cycle: rise on bit 3 while pending[3]=1, with `ack`, `ack_id`=3 → pending[3]=1 and `ovf`[3]=0.
- Lines 8'h81 pending, assert `rst_n`=0 for one edge → `pend_out`, `ovf`, `irq` = 0. `req_in`=8'h01 held through release → `pend_out`=8'h01 once the mask is re-enabled.
